spi_adc_responder: RTL and testbench
====================================

Name: spi_adc_responder

Overview:
Synthesizable SPI slave that emulates an MCP3008-style 8-channel, 10-bit ADC. It serves channel values supplied on parallel inputs. Used as the far-end responder for on-FPGA loopback and bring-up of the ADC reader path, so the reader can be exercised without the physical ADC. SPI pins are sampled in the clk domain through synchronizers; no SCK-clocked logic.

Parameters:
NUM_CH, 8, number of emulated channels (fixed 8; 3-bit select)
DATA_W, 10, conversion width, MSB first on MISO
SYNC_STAGES, 2, flip-flop stages on spi_sck/spi_cs/spi_mosi (min 2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
spi_sck  in  1  SPI clock from master, mode 0,0 (idle low)
spi_cs  in  1  chip select, active low
spi_mosi  in  1  command bits from master
spi_miso  out  1  conversion data to master
spi_miso_oe  out  1  1 = drive MISO (top-level tristate enable)
ch_data  in  NUM_CH*DATA_W  flat channel values, ch n at [n*DATA_W +: DATA_W]
cmd_valid  out  1  1-clk pulse when a full command (start+SGL+D2..D0) is decoded
cmd_sgl  out  1  decoded SGL/DIFF bit, held until next cmd_valid
cmd_ch  out  3  decoded D2..D0, held until next cmd_valid
frame_err  out  1  1-clk pulse when CS deasserts before the last data bit is shifted out

Behaviour:
- Reset values: spi_miso=0, spi_miso_oe=0, cmd_valid=0, cmd_sgl=0, cmd_ch=0, frame_err=0, state=IDLE.
- Clock ratio: clk frequency must be at least 4x SCK frequency.
- Edge detect: rise/fall are computed from the synchronized SCK and its 1-clk delayed copy. MOSI is sampled from its synchronized copy on a detected rise. MISO updates on a detected fall.
- Latency: MISO updates SYNC_STAGES+1 clk after the physical SCK fall.
- States:
  - IDLE: CS high, oe=0, miso=0. Synced CS low -> WAIT_START, oe=1, miso=0.
  - WAIT_START: on each rise, MOSI=0 is a leading zero (any count allowed); MOSI=1 is the start bit -> CMD, bit counter=0.
  - CMD: capture SGL, D2, D1, D0 on 4 successive rises. On the 4th rise:
    - latch sample register from ch_data (selection below);
    - pulse cmd_valid; update cmd_sgl/cmd_ch;
    - -> NULL.
  - NULL: next fall drives miso=0 (null bit) -> DATA, data counter=DATA_W-1.
  - DATA: each fall drives sample[counter] and decrements the counter. After bit 0 has been driven -> TRAIL.
  - TRAIL: miso=0 on further falls. MOSI is ignored. Stay until CS high.
- CS high (synced) in any state -> IDLE in the same cycle; oe=0, miso=0. If the state was CMD, NULL, or DATA, pulse frame_err (a trailing partial frame in WAIT_START is not an error).
- Selection, evaluated on the 4th command rise:
  - SGL=1: sample = ch_data[ch].
  - SGL=0 (pseudo-differential pair p = ch[2:1]): D0=0 -> IN+=ch 2p, IN-=ch 2p+1; D0=1 -> swapped. sample = IN+ - IN- if IN+ >= IN-, else 0. Compute at DATA_W+1 bits; no wrap.
- Sample stability: the sample is latched once per frame. ch_data changes after latching do not affect the current frame.
- Simultaneous events: if the CS-high detect and an SCK edge land in the same clk, CS wins; the edge is ignored.
- Reset mid-frame: all outputs return to reset values immediately (async). The master's next CS-low starts a fresh frame.
- Back-to-back frames: a CS high of at least 2 clk (post-sync) between frames is required and sufficient.

Decomposition:
- Package spi_adc_pkg: state encoding localparams (IDLE, WAIT_START, CMD, NULL, DATA, TRAIL), CMD_BITS=4, DATA_W default, and the channel-select helper function (single/diff with clamp). The reader side shares the same package for command constants.
- Sub-module spi_pin_sync: SYNC_STAGES-deep synchronizer for sck/cs/mosi, with sck_rise, sck_fall, cs_active outputs. Everything else lives in spi_adc_responder.

Test Plan:
- Single CH1, ch_data[1]=0x2A5, master sends 11001 then 12 more clocks -> cmd_valid pulse with cmd_sgl=1, cmd_ch=1; MISO after the null bit = 1010100101; then 0.
- Seven leading zeros before the start bit, CH7=0x3FF -> frame decoded identically; MISO data = ten 1s; no frame_err.
- Diff D2..D0=001, ch0=100, ch1=300 -> data=200 (0x0C8). Diff 000 on the same values -> data=0 (clamped).
- Latch check: change ch_data[1] from 0x155 to 0x2AA one clk after cmd_valid -> MISO still shifts 0x155.
- CS raised after 4 data bits -> frame_err pulse; oe=0 within SYNC_STAGES+2 clk. Next frame to CH3=0x001 reads correctly.
- Async rst_n asserted mid-DATA -> all outputs 0 immediately. After release, the next frame reads the correct value.

Source files
------------

// File: rtl/spi_adc_pkg.sv
// -----------------------------------------------------------------------------
// spi_adc_pkg
// Shared constants, state encoding and channel-select helper for the emulated
// MCP3008-style ADC. The ADC reader side imports the same package so both ends
// agree on command framing.
// -----------------------------------------------------------------------------
package spi_adc_pkg;

  localparam int ADC_NUM_CH = 8;
  localparam int ADC_DATA_W = 10;
  localparam int CMD_BITS   = 4;   // SGL, D2, D1, D0 after the start bit

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    CMD,
    NULL,
    DATA,
    TRAIL
  } adc_state_e;

  // Single-ended: value of channel ch.
  // Pseudo-differential: IN+ is always channel ch and IN- its pair partner
  // (ch with bit 0 flipped); a negative difference clamps to zero. The
  // subtraction runs one bit wider so it cannot wrap.
  function automatic logic [ADC_DATA_W-1:0] adc_select(
    input logic [ADC_NUM_CH*ADC_DATA_W-1:0] ch_data,
    input logic                             sgl,
    input logic [2:0]                       ch
  );
    logic [2:0]            neg_ch;
    logic [ADC_DATA_W:0]   pos_v;
    logic [ADC_DATA_W:0]   neg_v;
    logic [ADC_DATA_W:0]   diff_v;
    logic [ADC_DATA_W-1:0] result;
    neg_ch = {ch[2:1], ~ch[0]};
    pos_v  = {1'b0, ch_data[int'(ch)*ADC_DATA_W +: ADC_DATA_W]};
    neg_v  = {1'b0, ch_data[int'(neg_ch)*ADC_DATA_W +: ADC_DATA_W]};
    diff_v = pos_v - neg_v;
    if (sgl) begin
      result = pos_v[ADC_DATA_W-1:0];
    end else if (pos_v >= neg_v) begin
      result = diff_v[ADC_DATA_W-1:0];
    end else begin
      result = '0;
    end
    return result;
  endfunction

endpackage

// File: rtl/spi_adc_responder_if.sv
// -----------------------------------------------------------------------------
// spi_adc_responder_if
// SPI pin bundle between an ADC reader (master) and the emulated ADC (slave).
//   spi_sck     : serial clock, mode 0 (idle low), master -> slave
//   spi_cs      : chip select, active low,         master -> slave
//   spi_mosi    : command bits,                    master -> slave
//   spi_miso    : conversion data,                 slave  -> master
//   spi_miso_oe : tristate enable for MISO pad,    slave  -> top level
// -----------------------------------------------------------------------------
interface spi_adc_responder_if;
  logic spi_sck;
  logic spi_cs;
  logic spi_mosi;
  logic spi_miso;
  logic spi_miso_oe;

  modport master (
    output spi_sck, spi_cs, spi_mosi,
    input  spi_miso, spi_miso_oe
  );

  modport slave (
    input  spi_sck, spi_cs, spi_mosi,
    output spi_miso, spi_miso_oe
  );
endinterface

// File: rtl/spi_pin_sync.sv
// -----------------------------------------------------------------------------
// spi_pin_sync
// Brings the asynchronous SPI pins into the clk domain and derives SCK edges.
//   clk, rst_n          : system clock, async active-low reset
//   sck, cs, mosi       : raw SPI pins
//   sck_rise, sck_fall  : 1-clk pulses on synchronized SCK edges
//   cs_active           : synchronized chip select, 1 = selected
//   mosi_s              : synchronized MOSI
// -----------------------------------------------------------------------------
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sck,
  input  logic cs,
  input  logic mosi,
  output logic sck_rise,
  output logic sck_fall,
  output logic cs_active,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_prev_q, sck_prev_d;

  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sck_prev_d  = sck_sync_q[SYNC_STAGES-1];
  end

  // CS chain resets to the deselected level so no frame starts out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_prev_q  <= sck_prev_d;
    end
  end

  assign sck_rise  =  sck_sync_q[SYNC_STAGES-1] & ~sck_prev_q;
  assign sck_fall  = ~sck_sync_q[SYNC_STAGES-1] &  sck_prev_q;
  assign cs_active = ~cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    =  mosi_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_adc_responder.sv
// -----------------------------------------------------------------------------
// spi_adc_responder
// SPI slave emulating an 8-channel, 10-bit MCP3008-style ADC, serving values
// from ch_data. All logic runs on clk; SPI pins are oversampled.
//   clk, rst_n  : system clock (>= 4x SCK), async active-low reset
//   spi         : SPI pin bundle (slave side)
//   ch_data     : channel values, ch n at [n*DATA_W +: DATA_W]
//   cmd_valid   : 1-clk pulse when start+SGL+D2..D0 has been decoded
//   cmd_sgl     : last decoded SGL/DIFF bit
//   cmd_ch      : last decoded D2..D0
//   frame_err   : 1-clk pulse when CS rises before the last data bit is out
// -----------------------------------------------------------------------------
module spi_adc_responder
  import spi_adc_pkg::*;
#(
  parameter int NUM_CH      = ADC_NUM_CH,
  parameter int DATA_W      = ADC_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  spi_adc_responder_if.slave       spi,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     cmd_valid,
  output logic                     cmd_sgl,
  output logic [2:0]               cmd_ch,
  output logic                     frame_err
);

  localparam int CNT_W = $clog2(DATA_W);

  logic sck_rise, sck_fall, cs_active, mosi_s;

  spi_pin_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .sck       (spi.spi_sck),
    .cs        (spi.spi_cs),
    .mosi      (spi.spi_mosi),
    .sck_rise  (sck_rise),
    .sck_fall  (sck_fall),
    .cs_active (cs_active),
    .mosi_s    (mosi_s)
  );

  adc_state_e        state_q, state_d;
  logic [1:0]        bit_cnt_q, bit_cnt_d;
  logic [2:0]        cmd_shift_q, cmd_shift_d;   // {SGL, D2, D1} while in CMD
  logic [CNT_W-1:0]  data_cnt_q, data_cnt_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              miso_q, miso_d;
  logic              oe_q, oe_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              cmd_sgl_q, cmd_sgl_d;
  logic [2:0]        cmd_ch_q, cmd_ch_d;
  logic              frame_err_q, frame_err_d;
  logic [2:0]        ch_now;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    cmd_shift_d = cmd_shift_q;
    data_cnt_d  = data_cnt_q;
    sample_d    = sample_q;
    miso_d      = miso_q;
    oe_d        = oe_q;
    cmd_valid_d = 1'b0;
    cmd_sgl_d   = cmd_sgl_q;
    cmd_ch_d    = cmd_ch_q;
    frame_err_d = 1'b0;
    ch_now      = {cmd_shift_q[1:0], mosi_s};

    // Deselect overrides any SCK edge seen in the same cycle.
    if (!cs_active) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      miso_d  = 1'b0;
      if (state_q == CMD || state_q == NULL || state_q == DATA) begin
        frame_err_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = WAIT_START;
          oe_d    = 1'b1;
          miso_d  = 1'b0;
        end
        WAIT_START: begin
          if (sck_rise && mosi_s) begin
            state_d   = CMD;
            bit_cnt_d = '0;
          end
        end
        CMD: begin
          if (sck_rise) begin
            if (bit_cnt_q == 2'(CMD_BITS - 1)) begin
              sample_d    = adc_select(ch_data, cmd_shift_q[2], ch_now);
              cmd_valid_d = 1'b1;
              cmd_sgl_d   = cmd_shift_q[2];
              cmd_ch_d    = ch_now;
              state_d     = NULL;
            end else begin
              cmd_shift_d = {cmd_shift_q[1:0], mosi_s};
              bit_cnt_d   = bit_cnt_q + 2'd1;
            end
          end
        end
        NULL: begin
          if (sck_fall) begin
            miso_d     = 1'b0;
            data_cnt_d = CNT_W'(DATA_W - 1);
            state_d    = DATA;
          end
        end
        DATA: begin
          if (sck_fall) begin
            miso_d = sample_q[data_cnt_q];
            if (data_cnt_q == '0) begin
              state_d = TRAIL;
            end else begin
              data_cnt_d = data_cnt_q - 1'b1;
            end
          end
        end
        TRAIL: begin
          if (sck_fall) begin
            miso_d = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          oe_d    = 1'b0;
          miso_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      cmd_shift_q <= '0;
      data_cnt_q  <= '0;
      sample_q    <= '0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_sgl_q   <= 1'b0;
      cmd_ch_q    <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      cmd_shift_q <= cmd_shift_d;
      data_cnt_q  <= data_cnt_d;
      sample_q    <= sample_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_sgl_q   <= cmd_sgl_d;
      cmd_ch_q    <= cmd_ch_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign spi.spi_miso    = miso_q;
  assign spi.spi_miso_oe = oe_q;
  assign cmd_valid       = cmd_valid_q;
  assign cmd_sgl         = cmd_sgl_q;
  assign cmd_ch          = cmd_ch_q;
  assign frame_err       = frame_err_q;

endmodule

// File: tb/tb_spi_adc_responder.sv
// -----------------------------------------------------------------------------
// tb_spi_adc_responder
// Drives directed SPI frames into spi_adc_responder. Each frame pushes its
// expected command, MISO bit stream and (if any) frame error into queues;
// independent monitors pop and compare when the DUT presents cmd_valid,
// frame_err, or when the master ends a frame.
// -----------------------------------------------------------------------------
module tb_spi_adc_responder;
  import spi_adc_pkg::*;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [79:0] ch_data = '0;
  logic        cmd_valid, cmd_sgl, frame_err;
  logic [2:0]  cmd_ch;

  spi_adc_responder_if spi_bus ();

  always #5 clk = ~clk;

  spi_adc_responder #(
    .NUM_CH      (8),
    .DATA_W      (10),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi       (spi_bus.slave),
    .ch_data   (ch_data),
    .cmd_valid (cmd_valid),
    .cmd_sgl   (cmd_sgl),
    .cmd_ch    (cmd_ch),
    .frame_err (frame_err)
  );

  typedef struct {
    logic [63:0] bits;
    int          n;
  } frame_t;

  frame_t     exp_frames[$];
  logic [3:0] exp_cmds[$];
  int         exp_errs[$];

  int n_tests = 0;
  int n_fail  = 0;
  int frame_no = 0;

  // monitor state
  bit          in_frame = 1'b0;
  logic [63:0] cap = '0;
  int          cap_n = 0;
  int          mon_count = 0;
  int          mon_cur = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got event, expected none", name);
  endtask

  task automatic set_ch(input int n, input logic [9:0] v);
    ch_data[n*10 +: 10] = v;
  endtask

  // One SCK period: MOSI set just after a fall, 4 clk low, 4 clk high.
  // With hook set, ch_data[hook_ch] is rewritten one clk after cmd_valid.
  task automatic sck_cycle(input logic b, input bit hook, input int hook_ch,
                           input logic [9:0] hook_val);
    int k;
    @(negedge clk);
    spi_bus.spi_mosi = b;
    repeat (3) @(negedge clk);
    spi_bus.spi_sck = 1'b1;
    if (hook) begin
      k = 0;
      while (cmd_valid !== 1'b1 && k < 16) begin
        @(negedge clk);
        k++;
      end
      check("latch_cmd_valid_seen", 64'(k < 16), 64'd1);
      @(posedge clk);
      #1;
      set_ch(hook_ch, hook_val);
    end
    repeat (4) @(negedge clk);
    spi_bus.spi_sck = 1'b0;
  endtask

  // post_clks: SCK periods after the D0 clock. Rise 1 reads the null bit,
  // rises 2..11 read B9..B0, later rises read 0. rst_at >= 0 asserts rst_n
  // after that many post clocks instead of finishing the frame.
  task automatic run_frame(input int lead, input logic sgl, input logic [2:0] ch,
                           input int post_clks, input logic [9:0] exp_data,
                           input bit do_latch, input int latch_ch,
                           input logic [9:0] latch_val, input int rst_at);
    frame_t f;
    int     cur;
    int     n_post;
    int     k;
    bit     err;
    cur    = frame_no;
    frame_no++;
    n_post = (rst_at >= 0) ? rst_at : post_clks;
    err    = (rst_at < 0) && (post_clks <= 9);
    f.bits = '0;
    f.n    = 0;
    for (int i = 0; i < lead + 5; i++) begin
      f.bits = {f.bits[62:0], 1'b0};
      f.n++;
    end
    for (int j = 1; j <= n_post; j++) begin
      f.bits = {f.bits[62:0], (j >= 2 && j <= 11) ? exp_data[11-j] : 1'b0};
      f.n++;
    end
    exp_frames.push_back(f);
    exp_cmds.push_back({sgl, ch});
    if (err) exp_errs.push_back(cur);

    @(negedge clk);
    spi_bus.spi_cs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < lead; i++) sck_cycle(1'b0, 1'b0, 0, 10'd0);
    sck_cycle(1'b1, 1'b0, 0, 10'd0);
    sck_cycle(sgl, 1'b0, 0, 10'd0);
    sck_cycle(ch[2], 1'b0, 0, 10'd0);
    sck_cycle(ch[1], 1'b0, 0, 10'd0);
    sck_cycle(ch[0], do_latch, latch_ch, latch_val);
    for (int j = 0; j < n_post; j++) sck_cycle(1'b0, 1'b0, 0, 10'd0);

    if (rst_at >= 0) begin
      @(negedge clk);
      check("pre_rst_oe", 64'(spi_bus.spi_miso_oe), 64'd1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_outputs",
            64'({spi_bus.spi_miso, spi_bus.spi_miso_oe, cmd_valid, cmd_sgl, cmd_ch, frame_err}),
            64'd0);
      @(negedge clk);
      spi_bus.spi_cs = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
    end else begin
      @(negedge clk);
      spi_bus.spi_cs = 1'b1;
      if (err) begin
        k = 0;
        while (spi_bus.spi_miso_oe !== 1'b0 && k < 8) begin
          @(posedge clk);
          #1;
          k++;
        end
        check("err_oe_release_clks", 64'(k <= SYNC + 2), 64'd1);
      end
    end
    repeat (8) @(negedge clk);
  endtask

  // ---------------- monitors ----------------
  initial forever begin
    @(negedge spi_bus.spi_cs);
    in_frame  = 1'b1;
    cap       = '0;
    cap_n     = 0;
    mon_cur   = mon_count;
    mon_count++;
  end

  initial forever begin
    @(posedge spi_bus.spi_sck);
    if (in_frame) begin
      cap = {cap[62:0], spi_bus.spi_miso};
      cap_n++;
    end
  end

  initial forever begin
    frame_t f;
    @(posedge spi_bus.spi_cs);
    if (in_frame) begin
      in_frame = 1'b0;
      if (exp_frames.size() == 0) begin
        fail_now("unexpected_frame");
      end else begin
        f = exp_frames.pop_front();
        check($sformatf("frame%0d_miso_bits", mon_cur), cap, f.bits);
        check($sformatf("frame%0d_miso_len", mon_cur), 64'(cap_n), 64'(f.n));
      end
    end
  end

  initial forever begin
    logic [3:0] e;
    @(negedge clk);
    if (cmd_valid === 1'b1) begin
      if (exp_cmds.size() == 0) begin
        fail_now("unexpected_cmd_valid");
      end else begin
        e = exp_cmds.pop_front();
        check($sformatf("frame%0d_cmd_sgl_ch", mon_cur), 64'({cmd_sgl, cmd_ch}), 64'(e));
      end
    end
  end

  initial forever begin
    int e;
    @(negedge clk);
    if (frame_err === 1'b1) begin
      if (exp_errs.size() == 0) begin
        fail_now("unexpected_frame_err");
      end else begin
        e = exp_errs.pop_front();
        check("frame_err_frame_id", 64'(mon_cur), 64'(e));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    spi_bus.spi_sck  = 1'b0;
    spi_bus.spi_cs   = 1'b1;
    spi_bus.spi_mosi = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs_held",
          64'({spi_bus.spi_miso, spi_bus.spi_miso_oe, cmd_valid, cmd_sgl, cmd_ch, frame_err}),
          64'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_outputs_released",
          64'({spi_bus.spi_miso, spi_bus.spi_miso_oe, cmd_valid, cmd_sgl, cmd_ch, frame_err}),
          64'd0);

    // single CH1 = 0x2A5
    set_ch(1, 10'h2A5);
    run_frame(0, 1'b1, 3'd1, 12, 10'h2A5, 1'b0, 0, 10'd0, -1);
    // seven leading zeros, CH7 = 0x3FF
    set_ch(7, 10'h3FF);
    run_frame(7, 1'b1, 3'd7, 12, 10'h3FF, 1'b0, 0, 10'd0, -1);
    // diff 001: 300 - 100 = 200; diff 000: 100 - 300 clamps to 0
    set_ch(0, 10'd100);
    set_ch(1, 10'd300);
    run_frame(0, 1'b0, 3'd1, 12, 10'h0C8, 1'b0, 0, 10'd0, -1);
    run_frame(0, 1'b0, 3'd0, 12, 10'h000, 1'b0, 0, 10'd0, -1);
    // diff 110 with equal inputs -> 0
    set_ch(6, 10'h155);
    set_ch(7, 10'h155);
    run_frame(0, 1'b0, 3'd6, 12, 10'h000, 1'b0, 0, 10'd0, -1);
    // diff 111: CH7 = 0x3FF, CH6 = 0x001 -> 0x3FE
    set_ch(6, 10'h001);
    set_ch(7, 10'h3FF);
    run_frame(0, 1'b0, 3'd7, 12, 10'h3FE, 1'b0, 0, 10'd0, -1);
    // latch: CH1 0x155 rewritten to 0x2AA after cmd_valid
    set_ch(1, 10'h155);
    run_frame(0, 1'b1, 3'd1, 12, 10'h155, 1'b1, 1, 10'h2AA, -1);
    // CS raised after 4 data bits of CH2 = 0x3C3
    set_ch(2, 10'h3C3);
    run_frame(0, 1'b1, 3'd2, 5, 10'h3C3, 1'b0, 0, 10'd0, -1);
    // recovery frame, CH3 = 0x001
    set_ch(3, 10'h001);
    run_frame(0, 1'b1, 3'd3, 12, 10'h001, 1'b0, 0, 10'd0, -1);
    // async reset mid-DATA on CH5 = 0x1B6, then a clean read
    set_ch(5, 10'h1B6);
    run_frame(0, 1'b1, 3'd5, 12, 10'h1B6, 1'b0, 0, 10'd0, 6);
    check("post_rst_cmd_fields", 64'({cmd_sgl, cmd_ch}), 64'd0);
    run_frame(2, 1'b1, 3'd5, 12, 10'h1B6, 1'b0, 0, 10'd0, -1);

    repeat (20) @(negedge clk);
    check("frames_drained", 64'(exp_frames.size()), 64'd0);
    check("cmds_drained", 64'(exp_cmds.size()), 64'd0);
    check("errs_drained", 64'(exp_errs.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound so a stuck DUT still ends in a summary.
  initial begin
    #2000000;
    n_tests++;
    n_fail++;
    $display("FAIL timeout: got no completion, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
